bubble_sort_engine: RTL and testbench
=====================================

# bubble_sort_engine

Sequential sort controller that initiates compare requests to the 64-bit ALU and sorts an array of doublewords in data memory in place, ascending unsigned. It sits beside the datapath: it drives the ALU operand and opcode inputs, consumes the ALU `Is_Greater` flag, and owns the data-memory port while busy. It replaces the software bubble-sort loop with a hardware engine started by a single pulse.

## Interface
- `DATA_W`, 64: element width; matches ALU operand width.
- `ADDR_W`, 32: byte-address width of the data-memory port.
- `CNT_W`, 16: width of the element count.
- `clk` in 1: single clock, all state on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `base_addr` in ADDR_W: byte address of element 0; must be 8-byte aligned; sampled with `start`.
- `count` in CNT_W: number of elements; sampled with `start`.
- `mem_addr` out ADDR_W: doubleword byte address.
- `mem_rd_en` out 1: read strobe; `mem_rdata` is valid the following cycle.
- `mem_rdata` in DATA_W: read data.
- `mem_wr_en` out 1: write strobe; write commits at that edge.
- `mem_wdata` out DATA_W: write data.
- `alu_a`, `alu_b` out DATA_W: compare operands.
- `alu_op` out 4: constant 4'b0110 (subtract) while busy, 4'b0000 otherwise.
- `alu_is_greater` in 1: combinational ALU flag, unsigned `alu_a > alu_b`.
- `busy` out 1: high from the cycle after `start` is accepted until DONE inclusive.
- `done` out 1: one-cycle pulse at completion.
- `swap_count` out 32: swaps performed in the current or last sort; cleared on `start`.

## Operation
- States: IDLE, RD_A, RD_B, LATCH, CMP, WR_A, WR_B, NEXT, DONE.
- IDLE with `start` and `count >= 2`: latch base and count; set `i=0`, `limit=count-1`, `swapped=0`, `swap_count=0`; go to RD_A.
- IDLE with `start` and `count < 2`: go directly to DONE; no memory access.
- RD_A: `mem_rd_en=1`, `mem_addr=base+8*i`.
- RD_B: `mem_rd_en=1`, `mem_addr=base+8*(i+1)`; capture `mem_rdata` into `reg_a`.
- LATCH: capture `mem_rdata` into `reg_b`.
- CMP: `alu_a=reg_a`, `alu_b=reg_b`. If `alu_is_greater` go to WR_A, else go to NEXT. Equal values never swap.
- WR_A: write `reg_b` to `base+8*i`.
- WR_B: write `reg_a` to `base+8*(i+1)`; increment `swap_count`; set `swapped`; go to NEXT.
- NEXT when `i+1 < limit`: `i++`, go to RD_A.
- NEXT at end of pass: if `limit==1` go to DONE; otherwise `limit--`, `i=0`, `swapped=0`, go to RD_A (subject to early exit, see Configuration).
- DONE: `done=1` for one cycle, then IDLE.
- `start` while busy is ignored.
- Address arithmetic is modulo 2^ADDR_W; no bounds checking.

## Timing
- Reset values: state IDLE; `busy`, `done`, `mem_rd_en`, `mem_wr_en` = 0; `mem_addr`, `mem_wdata`, `alu_a`, `alu_b`, `swap_count` = 0; `alu_op` = 4'b0000.
- Cost per compare: 5 cycles without a swap (RD_A..CMP, NEXT); 7 cycles with a swap.
- `done` is asserted in the cycle after the last NEXT. For `count < 2`, `done` is asserted in the cycle after `start`.
- Reset asserted mid-sort: immediately returns to IDLE with all strobes low. Memory keeps any completed writes. If reset hits between WR_A and WR_B, a duplicated element is possible; this is accepted.
- Memory outputs are registered state decodes; no combinational path from `mem_rdata` to any output.

## Configuration
- `BUBBLE_EARLY_EXIT_EN` defined: at end of pass, if `swapped==0`, go to DONE.
- Not defined: always run all `count-1` passes; `swapped` is not implemented.

## Structure
- Shared package holds:
  - State encoding enum.
  - ALU opcode constants (SUB = 4'b0110, AND = 4'b0000).
  - Doubleword stride constant 8.
- No sub-module is needed. Optionally split out `bubble_sort_addr_gen` (i/limit counters and address calculation).

## Test plan
- Array [4,3,2,1], `count=4` → memory reads [1,2,3,4]; `swap_count=6`; `done` one cycle.
- [1,2,3,4] with `BUBBLE_EARLY_EXIT_EN` → no writes; `done` 16 cycles after `start` (3 compares × 5 + 1).
- [0xFFFF_FFFF_FFFF_FFFF, 1] → [1, 0xFFFF…FFFF] (unsigned order); `swap_count=1`.
- [5,5,5] → no `mem_wr_en` ever; `swap_count=0`.
- `count=1` and `count=0` → `done` the cycle after `start`; `mem_rd_en` never high.
- `reset_n` low during WR_A → next cycle IDLE; `busy=0`; strobes low; a new `start` sorts correctly.

Source files
------------

// File: rtl/bubble_sort_engine_pkg.sv
// Shared types and constants for the bubble-sort engine: FSM encoding,
// ALU opcodes driven while busy/idle, and the doubleword address stride.
package bubble_sort_engine_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_A,
    S_RD_B,
    S_LATCH,
    S_CMP,
    S_WR_A,
    S_WR_B,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [3:0]  ALU_OP_SUB = 4'b0110;
  localparam logic [3:0]  ALU_OP_AND = 4'b0000;
  localparam int unsigned DW_STRIDE  = 8;

endpackage

// File: rtl/bubble_sort_engine.sv
// In-place ascending unsigned bubble sort of doublewords in data memory using
// the external ALU compare flag. Optional early exit: BUBBLE_EARLY_EXIT_EN.
module bubble_sort_engine
  import bubble_sort_engine_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic              alu_is_greater,
  output logic              busy,
  output logic              done,
  output logic [31:0]       swap_count
);

  state_t            state_q;
  logic [ADDR_W-1:0] base_q, addr_q;
  logic [CNT_W-1:0]  i_q, limit_q;
  logic [DATA_W-1:0] reg_a_q, reg_b_q, wdata_q;
  logic [31:0]       swap_cnt_q;
  logic              busy_q, done_q, rd_en_q, wr_en_q;
  logic [3:0]        alu_op_q;

  logic [ADDR_W-1:0] addr_i_d, addr_i1_d;
  logic              pass_end_d, sort_end_d;

  assign addr_i_d   = base_q + ADDR_W'(i_q) * ADDR_W'(DW_STRIDE);
  assign addr_i1_d  = addr_i_d + ADDR_W'(DW_STRIDE);
  assign pass_end_d = (i_q + CNT_W'(1)) >= limit_q;

`ifdef BUBBLE_EARLY_EXIT_EN
  logic swapped_q;
  assign sort_end_d = (limit_q == CNT_W'(1)) || !swapped_q;
`else
  assign sort_end_d = (limit_q == CNT_W'(1));
`endif

  // Outputs are registered: each branch loads the strobes for the state it enters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      addr_q     <= '0;
      i_q        <= '0;
      limit_q    <= '0;
      reg_a_q    <= '0;
      reg_b_q    <= '0;
      wdata_q    <= '0;
      swap_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      alu_op_q   <= ALU_OP_AND;
`ifdef BUBBLE_EARLY_EXIT_EN
      swapped_q  <= 1'b0;
`endif
    end else begin
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          busy_q     <= 1'b1;
          alu_op_q   <= ALU_OP_SUB;
          swap_cnt_q <= '0;
          base_q     <= base_addr;
          i_q        <= '0;
          limit_q    <= count - CNT_W'(1);
`ifdef BUBBLE_EARLY_EXIT_EN
          swapped_q  <= 1'b0;
`endif
          if (count < CNT_W'(2)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_RD_A;
            rd_en_q <= 1'b1;
            addr_q  <= base_addr;
          end
        end
        S_RD_A: begin
          state_q <= S_RD_B;
          rd_en_q <= 1'b1;
          addr_q  <= addr_i1_d;
        end
        S_RD_B: begin
          reg_a_q <= mem_rdata;
          state_q <= S_LATCH;
        end
        S_LATCH: begin
          reg_b_q <= mem_rdata;
          state_q <= S_CMP;
        end
        S_CMP: if (alu_is_greater) begin
          state_q <= S_WR_A;
          wr_en_q <= 1'b1;
          addr_q  <= addr_i_d;
          wdata_q <= reg_b_q;
        end else begin
          state_q <= S_NEXT;
        end
        S_WR_A: begin
          state_q <= S_WR_B;
          wr_en_q <= 1'b1;
          addr_q  <= addr_i1_d;
          wdata_q <= reg_a_q;
        end
        S_WR_B: begin
          swap_cnt_q <= swap_cnt_q + 32'd1;
`ifdef BUBBLE_EARLY_EXIT_EN
          swapped_q  <= 1'b1;
`endif
          state_q    <= S_NEXT;
        end
        S_NEXT: if (!pass_end_d) begin
          i_q     <= i_q + CNT_W'(1);
          state_q <= S_RD_A;
          rd_en_q <= 1'b1;
          addr_q  <= addr_i1_d;
        end else if (sort_end_d) begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end else begin
          limit_q   <= limit_q - CNT_W'(1);
          i_q       <= '0;
`ifdef BUBBLE_EARLY_EXIT_EN
          swapped_q <= 1'b0;
`endif
          state_q   <= S_RD_A;
          rd_en_q   <= 1'b1;
          addr_q    <= base_q;
        end
        S_DONE: begin
          state_q  <= S_IDLE;
          busy_q   <= 1'b0;
          alu_op_q <= ALU_OP_AND;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_addr   = addr_q;
  assign mem_rd_en  = rd_en_q;
  assign mem_wr_en  = wr_en_q;
  assign mem_wdata  = wdata_q;
  assign alu_a      = reg_a_q;
  assign alu_b      = reg_b_q;
  assign alu_op     = alu_op_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign swap_count = swap_cnt_q;

endmodule

// File: tb/tb_bubble_sort_engine.sv
// Scoreboard bench for bubble_sort_engine: small synchronous memory + ALU
// compare model, directed arrays with hand-computed sorted results and latencies.
module tb_bubble_sort_engine;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] count = '0;
  logic [31:0] mem_addr;
  logic        mem_rd_en, mem_wr_en;
  logic [63:0] mem_rdata, mem_wdata;
  logic [63:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic        alu_is_greater;
  logic        busy, done;
  logic [31:0] swap_count;

  always #5 clk = ~clk;

  bubble_sort_engine dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .count(count), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_rdata(mem_rdata), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_is_greater(alu_is_greater), .busy(busy), .done(done),
    .swap_count(swap_count)
  );

  assign alu_is_greater = alu_a > alu_b;

  // 16-doubleword memory with a load port for the stimulus side.
  logic [63:0] mem [0:15];
  logic        ld_en = 1'b0;
  logic [3:0]  ld_idx = '0;
  logic [63:0] ld_val = '0;
  int          cyc = 0, wr_seen = 0, rd_seen = 0;
  logic        clr_cnt = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd_en) mem_rdata <= mem[mem_addr[6:3]];
    if (mem_wr_en) mem[mem_addr[6:3]] <= mem_wdata;
    else if (ld_en) mem[ld_idx] <= ld_val;
    if (clr_cnt) begin
      wr_seen <= 0;
      rd_seen <= 0;
    end else begin
      if (mem_wr_en) wr_seen <= wr_seen + 1;
      if (mem_rd_en) rd_seen <= rd_seen + 1;
    end
  end

  typedef struct packed {
    logic [3:0][63:0] v;
    logic [31:0]      base;
    int               n;
    int               swaps;
    int               lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0, errors = 0;
  int   start_cyc = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the oldest expectation on every done pulse.
  always @(negedge clk) begin
    prev_done <= done;
    if (reset_n && prev_done) chk("done_one_cycle", {63'd0, done}, 64'd0);
    if (reset_n && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with empty scoreboard");
      end else begin
        mon_e = sb.pop_front();
        chk("latency", 64'(cyc - start_cyc), 64'(mon_e.lat));
        chk("swap_count", {32'd0, swap_count}, 64'(mon_e.swaps));
        chk("writes", 64'(wr_seen), 64'(2 * mon_e.swaps));
        chk("any_read", {63'd0, rd_seen != 0}, {63'd0, mon_e.n >= 2});
        chk("busy_in_done", {63'd0, busy}, 64'd1);
        chk("alu_op_busy", {60'd0, alu_op}, 64'h6);
        for (int k = 0; k < mon_e.n && k < 4; k++)
          chk($sformatf("elem%0d", k), mem[4'(mon_e.base[6:3] + 4'(k))], mon_e.v[k]);
      end
    end
  end

  task automatic load(input logic [31:0] base, input logic [3:0][63:0] v, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      ld_en = 1'b1; ld_idx = 4'(base[6:3] + 4'(k)); ld_val = v[k];
    end
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic kick(input logic [31:0] base, input int n);
    @(posedge clk); #1;
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    base_addr = base; count = 16'(n); start = 1'b1; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run(input logic [31:0] base, input int n,
                     input logic [3:0][63:0] vin, input logic [3:0][63:0] vexp,
                     input int swaps, input int lat);
    exp_t e;
    load(base, vin, n);
    e.v = vexp; e.base = base; e.n = n; e.swaps = swaps; e.lat = lat;
    sb.push_back(e);
    kick(base, n);
    for (int k = 0; k < 400 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within bound, %0d pending", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  localparam logic [63:0] MAXV = 64'hFFFF_FFFF_FFFF_FFFF;
  int lat_sorted4, lat_equal3;
  bit seen_wr;

  initial begin
`ifdef BUBBLE_EARLY_EXIT_EN
    lat_sorted4 = 16; lat_equal3 = 11;
`else
    lat_sorted4 = 31; lat_equal3 = 16;
`endif
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_rd_en", {63'd0, mem_rd_en}, 64'd0);
    chk("rst_wr_en", {63'd0, mem_wr_en}, 64'd0);
    chk("rst_addr", {32'd0, mem_addr}, 64'd0);
    chk("rst_wdata", mem_wdata, 64'd0);
    chk("rst_alu_a", alu_a, 64'd0);
    chk("rst_alu_b", alu_b, 64'd0);
    chk("rst_swaps", {32'd0, swap_count}, 64'd0);
    chk("rst_alu_op", {60'd0, alu_op}, 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    run(32'h0,  4, {64'd1, 64'd2, 64'd3, 64'd4}, {64'd4, 64'd3, 64'd2, 64'd1}, 6, 43);
    chk("idle_alu_op", {60'd0, alu_op}, 64'd0);
    run(32'h40, 4, {64'd4, 64'd3, 64'd2, 64'd1}, {64'd4, 64'd3, 64'd2, 64'd1}, 0, lat_sorted4);
    run(32'h0,  2, {64'd0, 64'd0, 64'd1, MAXV}, {64'd0, 64'd0, MAXV, 64'd1}, 1, 8);
    run(32'h10, 1, {64'd0, 64'd0, 64'd0, 64'd7}, {64'd0, 64'd0, 64'd0, 64'd7}, 0, 1);
    run(32'h10, 0, '0, '0, 0, 1);
    run(32'h8,  3, {64'd0, 64'd5, 64'd5, 64'd5}, {64'd0, 64'd5, 64'd5, 64'd5}, 0, lat_equal3);

    // Reset while the first write strobe is up; the sort is abandoned.
    load(32'h0, {64'd0, 64'd0, 64'd1, 64'd2}, 2);
    kick(32'h0, 2);
    seen_wr = 1'b0;
    for (int k = 0; k < 50 && !seen_wr; k++) begin
      @(negedge clk);
      seen_wr = mem_wr_en;
    end
    chk("reached_wr_a", {63'd0, seen_wr}, 64'd1);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_wr_en", {63'd0, mem_wr_en}, 64'd0);
    chk("midrst_rd_en", {63'd0, mem_rd_en}, 64'd0);
    chk("midrst_swaps", {32'd0, swap_count}, 64'd0);
    @(negedge clk);
    chk("midrst_elem0_kept", mem[0], 64'd2);
    reset_n = 1'b1;
    @(negedge clk);
    run(32'h0, 3, {64'd0, 64'd8, 64'd7, 64'd9}, {64'd0, 64'd9, 64'd8, 64'd7}, 2, 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
